mdu_ctrl: RTL and testbench

//  Multiply/divide unit sequencer for the EXE stage. Owns the HI/LO registers.

---
 rtl/mdu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for EXE: owns HI/LO, runs MULT/MULTU in-line, drives divider IP handshakes.
// Optional registered multiply under `MDU_MUL_PIPE_EN.
//
// state | meaning
// IDLE  | ready for a new op; mult/mt commit combinationally here
// SEND  | presenting operands to the selected divider until both channels accept
// WAIT  | waiting for the selected divider result
// DRAIN | cancelled divide; swallow the next result without committing
// MUL   | (MDU_MUL_PIPE_EN only) registered product commits this cycle
module mdu_ctrl #(
   parameter int DATA_W      = 32,
   parameter int DIV_MAX_LAT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_W-1:0]     src1,
   input  logic [DATA_W-1:0]     src2,
   input  logic                  cancel,
   output logic                  done,
   output logic                  busy,
   output logic [DATA_W-1:0]     hi,
   output logic [DATA_W-1:0]     lo,
   output logic [DATA_W-1:0]     div_a_tdata,
   output logic [DATA_W-1:0]     div_b_tdata,
   output logic                  sdiv_a_tvalid,
   output logic                  sdiv_b_tvalid,
   input  logic                  sdiv_a_tready,
   input  logic                  sdiv_b_tready,
   input  logic [2*DATA_W-1:0]   sdiv_dout_tdata,
   input  logic                  sdiv_dout_tvalid,
   output logic                  udiv_a_tvalid,
   output logic                  udiv_b_tvalid,
   input  logic                  udiv_a_tready,
   input  logic                  udiv_b_tready,
   input  logic [2*DATA_W-1:0]   udiv_dout_tdata,
   input  logic                  udiv_dout_tvalid,
   output logic                  err_timeout
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam int TMR_W = (DIV_MAX_LAT > 1) ? $clog2(DIV_MAX_LAT) : 1;

`ifdef MDU_MUL_PIPE_EN
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DRAIN, S_MUL} state_t;
   logic [2*DATA_W-1:0] prod_q;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DRAIN} state_t;
`endif

   state_t              state, state_nxt;
   logic                sel_u, a_v, b_v, cancel_q;
   logic [TMR_W-1:0]    tmr;
   logic [DATA_W-1:0]   hi_nxt, lo_nxt;
   logic                accept, is_div, in_wait;
   logic                a_rdy, b_rdy, dout_vld;
   logic [2*DATA_W-1:0] dout_data, prod_s, prod_u, prod;

   assign accept    = start && !cancel;
   assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign prod_s    = {{DATA_W{src1[DATA_W-1]}}, src1} * {{DATA_W{src2[DATA_W-1]}}, src2};
   assign prod_u    = {{DATA_W{1'b0}}, src1} * {{DATA_W{1'b0}}, src2};
   assign prod      = (op == OP_MULT) ? prod_s : prod_u;
   assign a_rdy     = sel_u ? udiv_a_tready : sdiv_a_tready;
   assign b_rdy     = sel_u ? udiv_b_tready : sdiv_b_tready;
   assign dout_vld  = sel_u ? udiv_dout_tvalid : sdiv_dout_tvalid;
   assign dout_data = sel_u ? udiv_dout_tdata : sdiv_dout_tdata;
   assign in_wait   = (state == S_WAIT) || (state == S_DRAIN);

   assign busy          = (state != S_IDLE);
   assign div_a_tdata   = src1;
   assign div_b_tdata   = src2;
   assign sdiv_a_tvalid = a_v && !sel_u;
   assign sdiv_b_tvalid = b_v && !sel_u;
   assign udiv_a_tvalid = a_v && sel_u;
   assign udiv_b_tvalid = b_v && sel_u;

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      hi_nxt    = hi;
      lo_nxt    = lo;
      case (state)
         S_IDLE: if (accept) begin
            case (op)
`ifdef MDU_MUL_PIPE_EN
               OP_MULT, OP_MULTU: state_nxt = S_MUL;
`else
               OP_MULT, OP_MULTU: begin
                  done   = 1'b1;
                  hi_nxt = prod[2*DATA_W-1:DATA_W];
                  lo_nxt = prod[DATA_W-1:0];
               end
`endif
               OP_MTHI: begin
                  done   = 1'b1;
                  hi_nxt = src1;
               end
               OP_MTLO: begin
                  done   = 1'b1;
                  lo_nxt = src1;
               end
               OP_DIV, OP_DIVU: state_nxt = S_SEND;
               default: ;
            endcase
         end
         S_SEND: if ((!a_v || a_rdy) && (!b_v || b_rdy))
            state_nxt = (cancel || cancel_q) ? S_DRAIN : S_WAIT;
         // once timed out the FSM is frozen until reset
         S_WAIT: if (!err_timeout) begin
            if (cancel)
               state_nxt = dout_vld ? S_IDLE : S_DRAIN;
            else if (dout_vld) begin
               done      = 1'b1;
               lo_nxt    = dout_data[2*DATA_W-1:DATA_W];
               hi_nxt    = dout_data[DATA_W-1:0];
               state_nxt = S_IDLE;
            end
         end
         S_DRAIN: if (!err_timeout && dout_vld) state_nxt = S_IDLE;
`ifdef MDU_MUL_PIPE_EN
         S_MUL: begin
            if (!cancel) begin
               done   = 1'b1;
               hi_nxt = prod_q[2*DATA_W-1:DATA_W];
               lo_nxt = prod_q[DATA_W-1:0];
            end
            state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         hi          <= '0;
         lo          <= '0;
         sel_u       <= 1'b0;
         a_v         <= 1'b0;
         b_v         <= 1'b0;
         cancel_q    <= 1'b0;
         tmr         <= '0;
         err_timeout <= 1'b0;
`ifdef MDU_MUL_PIPE_EN
         prod_q      <= '0;
`endif
      end else begin
         state <= state_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         if (state == S_IDLE && accept && is_div) begin
            sel_u    <= (op == OP_DIVU);
            a_v      <= 1'b1;
            b_v      <= 1'b1;
            cancel_q <= 1'b0;
         end else if (state == S_SEND) begin
            if (a_rdy) a_v <= 1'b0;
            if (b_rdy) b_v <= 1'b0;
            if (cancel) cancel_q <= 1'b1;
         end
         if (state_nxt != state)
            tmr <= '0;
         else if (in_wait && !err_timeout && tmr != TMR_W'(DIV_MAX_LAT - 1))
            tmr <= tmr + 1'b1;
         if (state == S_WAIT && !err_timeout && !dout_vld && !cancel && tmr == TMR_W'(DIV_MAX_LAT - 1))
            err_timeout <= 1'b1;
         if (state == S_DRAIN && !err_timeout && !dout_vld && tmr == TMR_W'(DIV_MAX_LAT - 1))
            err_timeout <= 1'b1;
`ifdef MDU_MUL_PIPE_EN
         if (state == S_IDLE && accept && (op == OP_MULT || op == OP_MULTU))
            prod_q <= prod;
`endif
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} queued at issue, compared after each done.
// Builds with or without MDU_MUL_PIPE_EN.
module tb_mdu_ctrl;

   localparam int LAT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd7;
   logic [31:0] src1 = '0, src2 = '0;
   logic        cancel = 1'b0;
   logic        done, busy, err_timeout;
   logic [31:0] hi, lo, div_a_tdata, div_b_tdata;
   logic        sdiv_a_tvalid, sdiv_b_tvalid, udiv_a_tvalid, udiv_b_tvalid;
   logic        sa_rdy = 1'b0, sb_rdy = 1'b0, ua_rdy = 1'b0, ub_rdy = 1'b0;
   logic [63:0] sdout = '0, udout = '0;
   logic        sdout_v = 1'b0, udout_v = 1'b0;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   mdu_ctrl #(.DATA_W(32), .DIV_MAX_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
      .cancel(cancel), .done(done), .busy(busy), .hi(hi), .lo(lo),
      .div_a_tdata(div_a_tdata), .div_b_tdata(div_b_tdata),
      .sdiv_a_tvalid(sdiv_a_tvalid), .sdiv_b_tvalid(sdiv_b_tvalid),
      .sdiv_a_tready(sa_rdy), .sdiv_b_tready(sb_rdy),
      .sdiv_dout_tdata(sdout), .sdiv_dout_tvalid(sdout_v),
      .udiv_a_tvalid(udiv_a_tvalid), .udiv_b_tvalid(udiv_b_tvalid),
      .udiv_a_tready(ua_rdy), .udiv_b_tready(ub_rdy),
      .udiv_dout_tdata(udout), .udiv_dout_tvalid(udout_v),
      .err_timeout(err_timeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // scoreboard: each done pops one expected {hi,lo}, checked after the commit edge
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            check("hilo", {hi, lo}, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic d, output logic bz);
      tick();
      start = 1'b1; op = o; src1 = a; src2 = b;
      @(negedge clk);
      d = done; bz = busy;
      tick();
      start = 1'b0;
   endtask

   task automatic do_mul(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] e);
      logic d, bz;
      exp_q.push_back(e);
      issue(o, a, b, d, bz);
`ifdef MDU_MUL_PIPE_EN
      check({tag, "_done_start"}, {63'd0, d}, 64'd0);
      @(negedge clk);
      check({tag, "_busy_mul"}, {63'd0, busy}, 64'd1);
      check({tag, "_done_late"}, {63'd0, done}, 64'd1);
      tick();
      @(negedge clk);
      check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
`else
      check({tag, "_done_start"}, {63'd0, d}, 64'd1);
      check({tag, "_busy_start"}, {63'd0, bz}, 64'd0);
      @(negedge clk);
      check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
`endif
   endtask

   initial begin
      logic d, bz;
      tick(); tick();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_tvalid", {60'd0, sdiv_a_tvalid, sdiv_b_tvalid, udiv_a_tvalid, udiv_b_tvalid}, 64'd0);
      check("rst_err", {63'd0, err_timeout}, 64'd0);

      do_mul("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      do_mul("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});

      // DIV -7/2 with a_tready withheld for three SEND cycles
      sb_rdy = 1'b1; sa_rdy = 1'b0;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2, d, bz);
      check("div_done_start", {63'd0, d}, 64'd0);
      @(negedge clk);
      check("div_send1", {60'd0, sdiv_a_tvalid, sdiv_b_tvalid, udiv_a_tvalid, udiv_b_tvalid}, 64'hC);
      check("div_data", {div_a_tdata, div_b_tdata}, {32'hFFFF_FFF9, 32'd2});
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         check("div_send_a_hold", {62'd0, sdiv_a_tvalid, sdiv_b_tvalid}, 64'h2);
      end
      tick();
      sa_rdy = 1'b1;
      @(negedge clk);
      check("div_send_a_acc", {62'd0, sdiv_a_tvalid, sdiv_b_tvalid}, 64'h2);
      tick();
      sa_rdy = 1'b0; sb_rdy = 1'b0;
      @(negedge clk);
      check("div_wait_tvalid", {62'd0, sdiv_a_tvalid, sdiv_b_tvalid}, 64'd0);
      check("div_wait_busy", {63'd0, busy}, 64'd1);
      tick();
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
      sdout = {32'hFFFF_FFFD, 32'hFFFF_FFFF}; sdout_v = 1'b1;
      @(negedge clk);
      check("div_done", {63'd0, done}, 64'd1);
      tick();
      sdout_v = 1'b0;
      @(negedge clk);
      check("div_idle", {63'd0, busy}, 64'd0);

      // DIVU 100/7 cancelled in WAIT
      ua_rdy = 1'b1; ub_rdy = 1'b1;
      issue(3'd3, 32'd100, 32'd7, d, bz);
      @(negedge clk);
      check("divu_send", {60'd0, sdiv_a_tvalid, sdiv_b_tvalid, udiv_a_tvalid, udiv_b_tvalid}, 64'h3);
      tick();
      ua_rdy = 1'b0; ub_rdy = 1'b0;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("divu_drain_busy", {63'd0, busy}, 64'd1);
      tick();
      udout = {32'd14, 32'd2}; udout_v = 1'b1;
      @(negedge clk);
      check("divu_drain_done", {63'd0, done}, 64'd0);
      tick();
      udout_v = 1'b0;
      @(negedge clk);
      check("divu_drain_idle", {63'd0, busy}, 64'd0);
      check("divu_hilo_kept", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // start with cancel is ignored
      tick();
      start = 1'b1; op = 3'd5; src1 = 32'hA5A5_A5A5; cancel = 1'b1;
      @(negedge clk);
      check("cancel_start_done", {63'd0, done}, 64'd0);
      tick();
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      check("cancel_start_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});

      exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFD});
      issue(3'd4, 32'h1234_5678, 32'd0, d, bz);
      check("mthi_done", {63'd0, d}, 64'd1);

      // reset while DIVU sits in SEND, then a stray result in IDLE
      issue(3'd3, 32'd50, 32'd5, d, bz);
      @(negedge clk);
      check("rst_mid_send", {63'd0, udiv_a_tvalid}, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_tvalid", {60'd0, sdiv_a_tvalid, sdiv_b_tvalid, udiv_a_tvalid, udiv_b_tvalid}, 64'd0);
      tick();
      udout_v = 1'b1; udout = {32'd10, 32'd0};
      @(negedge clk);
      check("stray_done", {63'd0, done}, 64'd0);
      check("stray_busy", {63'd0, busy}, 64'd0);
      tick();
      udout_v = 1'b0;

      // timeout: withhold the signed result
      sa_rdy = 1'b1; sb_rdy = 1'b1;
      issue(3'd2, 32'd9, 32'd3, d, bz);
      tick();
      sa_rdy = 1'b0; sb_rdy = 1'b0;
      for (int i = 0; i < LAT - 1; i++) tick();
      @(negedge clk);
      check("tmo_before", {63'd0, err_timeout}, 64'd0);
      tick();
      @(negedge clk);
      check("tmo_set", {63'd0, err_timeout}, 64'd1);
      issue(3'd4, 32'hDEAD_BEEF, 32'd0, d, bz);
      check("tmo_busy_start", {63'd0, d}, 64'd0);
      @(negedge clk);
      check("tmo_hi_kept", {32'd0, hi}, 64'd0);
      tick();
      sdout_v = 1'b1; sdout = {32'd3, 32'd0};
      @(negedge clk);
      check("tmo_late_done", {63'd0, done}, 64'd0);
      tick();
      sdout_v = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      check("tmo_sticky", {62'd0, err_timeout, busy}, 64'h3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("tmo_rst", {62'd0, err_timeout, busy}, 64'd0);

      tick(); tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
